// File: rtl/mempool_tcdm_credit_shim.sv
// Per-core TCDM shim: credit-limits outstanding reads and buffers read responses in a small FIFO.
// Optional statistics counters are enabled with `define MEMPOOL_TCDM_SHIM_STATS_EN.
module mempool_tcdm_credit_shim #(
   parameter int unsigned AddrWidth      = 32,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   core_req_i,
   input  logic [AddrWidth-1:0]   core_addr_i,
   input  logic                   core_wen_i,
   input  logic [DataWidth-1:0]   core_wdata_i,
   input  logic [DataWidth/8-1:0] core_be_i,
   output logic                   core_gnt_o,
   output logic                   core_vld_o,
   input  logic                   core_rdy_i,
   output logic [DataWidth-1:0]   core_rdata_o,
   output logic                   ic_req_o,
   output logic [AddrWidth-1:0]   ic_addr_o,
   output logic                   ic_wen_o,
   output logic [DataWidth-1:0]   ic_wdata_o,
   output logic [DataWidth/8-1:0] ic_be_o,
   input  logic                   ic_gnt_i,
   input  logic                   ic_vld_i,
   output logic                   ic_rdy_o,
   input  logic [DataWidth-1:0]   ic_rdata_i,
   output logic [31:0]            stat_stall_o,
   output logic [31:0]            stat_reads_o
);

   localparam int unsigned CW = $clog2(MaxOutstanding + 1);
   localparam int unsigned PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam logic [CW-1:0] MaxCredit = CW'(MaxOutstanding);
   localparam logic [PW-1:0] LastIdx   = PW'(MaxOutstanding - 1);

   logic [CW-1:0]        r_credit;
   logic [CW-1:0]        r_count;
   logic [PW-1:0]        r_wr_ptr;
   logic [PW-1:0]        r_rd_ptr;
   logic [DataWidth-1:0] r_mem [MaxOutstanding];

   logic w_blocked;
   logic w_read_hs;
   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == LastIdx) ? '0 : p + PW'(1);
   endfunction

   // Blocking uses only the registered credit so a same-cycle pop never unblocks.
   assign w_blocked  = !core_wen_i && (r_credit == MaxCredit);
   assign ic_req_o   = core_req_i && !w_blocked;
   assign core_gnt_o = ic_gnt_i && ic_req_o;
   assign w_read_hs  = ic_req_o && ic_gnt_i && !core_wen_i;

   assign ic_addr_o  = core_addr_i;
   assign ic_wen_o   = core_wen_i;
   assign ic_wdata_o = core_wdata_i;
   assign ic_be_o    = core_be_i;

   assign w_full       = (r_count == MaxCredit);
   assign w_empty      = (r_count == '0);
   assign ic_rdy_o     = !w_full;
   assign core_vld_o   = !w_empty;
   assign w_push       = ic_vld_i && ic_rdy_o;
   assign w_pop        = core_vld_o && core_rdy_i;
   assign core_rdata_o = r_mem[r_rd_ptr];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_credit <= '0;
      end else begin
         case ({w_read_hs, w_pop})
            2'b10:   r_credit <= r_credit + CW'(1);
            2'b01:   r_credit <= r_credit - CW'(1);
            default: r_credit <= r_credit;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_count  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr] <= ic_rdata_i;
   end

`ifdef MEMPOOL_TCDM_SHIM_STATS_EN
   logic [31:0] r_stat_stall;
   logic [31:0] r_stat_reads;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_stat_stall <= '0;
         r_stat_reads <= '0;
      end else begin
         if (core_req_i && w_blocked) r_stat_stall <= r_stat_stall + 32'd1;
         if (w_read_hs)               r_stat_reads <= r_stat_reads + 32'd1;
      end
   end

   assign stat_stall_o = r_stat_stall;
   assign stat_reads_o = r_stat_reads;
`else
   assign stat_stall_o = '0;
   assign stat_reads_o = '0;
`endif

`ifndef SYNTHESIS
   // Credits make this unreachable; a hit means the interconnect sent an unrequested response.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(ic_vld_i && w_full))
            else $error("response arrived while response FIFO full; data dropped");
      end
   end
`endif

endmodule

// File: tb/tb_mempool_tcdm_credit_shim.sv
// Directed bench for mempool_tcdm_credit_shim (MaxOutstanding=2): vector table plus
// hand-written sequences for latency, backpressure, pointer wrap and mid-run reset.
module tb_mempool_tcdm_credit_shim;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MO = 2;

`ifdef MEMPOOL_TCDM_SHIM_STATS_EN
   localparam logic [31:0] ExpTblStall = 32'd5;
   localparam logic [31:0] ExpTblReads = 32'd3;
`else
   localparam logic [31:0] ExpTblStall = 32'd0;
   localparam logic [31:0] ExpTblReads = 32'd0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_i;
   logic          core_req_i, core_wen_i, core_rdy_i;
   logic [AW-1:0] core_addr_i;
   logic [DW-1:0] core_wdata_i;
   logic [DW/8-1:0] core_be_i;
   logic          core_gnt_o, core_vld_o;
   logic [DW-1:0] core_rdata_o;
   logic          ic_req_o, ic_wen_o;
   logic [AW-1:0] ic_addr_o;
   logic [DW-1:0] ic_wdata_o;
   logic [DW/8-1:0] ic_be_o;
   logic          ic_gnt_i, ic_vld_i, ic_rdy_o;
   logic [DW-1:0] ic_rdata_i;
   logic [31:0]   stat_stall_o, stat_reads_o;

   mempool_tcdm_credit_shim #(
      .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
   ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .core_req_i(core_req_i), .core_addr_i(core_addr_i), .core_wen_i(core_wen_i),
      .core_wdata_i(core_wdata_i), .core_be_i(core_be_i), .core_gnt_o(core_gnt_o),
      .core_vld_o(core_vld_o), .core_rdy_i(core_rdy_i), .core_rdata_o(core_rdata_o),
      .ic_req_o(ic_req_o), .ic_addr_o(ic_addr_o), .ic_wen_o(ic_wen_o),
      .ic_wdata_o(ic_wdata_o), .ic_be_o(ic_be_o), .ic_gnt_i(ic_gnt_i),
      .ic_vld_i(ic_vld_i), .ic_rdy_o(ic_rdy_o), .ic_rdata_i(ic_rdata_i),
      .stat_stall_o(stat_stall_o), .stat_reads_o(stat_reads_o)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Wait for the falling edge, apply inputs, then settle before checking.
   task automatic cyc(input logic req, input logic wen, input logic gnt,
                      input logic vld, input logic rdy, input logic [31:0] rdata);
      @(negedge clk);
      core_req_i = req;
      core_wen_i = wen;
      ic_gnt_i   = gnt;
      ic_vld_i   = vld;
      core_rdy_i = rdy;
      ic_rdata_i = rdata;
      #1;
   endtask

   typedef struct {
      logic        req, wen, gnt, vld, rdy;
      logic [31:0] rdata;
      logic        e_ic_req, e_gnt, e_vld, e_ic_rdy;
      logic [31:0] e_rdata;
      logic [1:0]  e_credit;
   } vec_t;

   vec_t tbl[13];

   initial begin
      //          req  wen  gnt  vld  rdy  rdata      icreq gnt  vld  icrdy e_rdata  credit
      tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,      1'b0,1'b0,1'b0,1'b1,32'h0,     2'd0};
      tbl[1]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,      1'b1,1'b1,1'b0,1'b1,32'h0,     2'd0};
      tbl[2]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,      1'b1,1'b1,1'b0,1'b1,32'h0,     2'd1};
      tbl[3]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,      1'b0,1'b0,1'b0,1'b1,32'h0,     2'd2};
      tbl[4]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,      1'b1,1'b1,1'b0,1'b1,32'h0,     2'd2};
      tbl[5]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,32'hA1,     1'b0,1'b0,1'b0,1'b1,32'h0,     2'd2};
      tbl[6]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,32'hA2,     1'b0,1'b0,1'b1,1'b1,32'hA1,    2'd2};
      tbl[7]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,      1'b0,1'b0,1'b1,1'b0,32'hA1,    2'd2};
      tbl[8]  = '{1'b1,1'b0,1'b1,1'b0,1'b1,32'h0,      1'b0,1'b0,1'b1,1'b0,32'hA1,    2'd2};
      tbl[9]  = '{1'b1,1'b0,1'b1,1'b0,1'b1,32'h0,      1'b1,1'b1,1'b1,1'b1,32'hA2,    2'd1};
      tbl[10] = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'hA3,     1'b0,1'b0,1'b0,1'b1,32'h0,     2'd1};
      tbl[11] = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,      1'b0,1'b0,1'b1,1'b1,32'hA3,    2'd1};
      tbl[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,      1'b0,1'b0,1'b0,1'b1,32'h0,     2'd0};

      rst_i        = 1'b1;
      core_req_i   = 1'b0;
      core_wen_i   = 1'b0;
      core_rdy_i   = 1'b0;
      core_addr_i  = 32'h0;
      core_wdata_i = 32'h0;
      core_be_i    = 4'h0;
      ic_gnt_i     = 1'b0;
      ic_vld_i     = 1'b0;
      ic_rdata_i   = 32'h0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_core_vld", {31'b0, core_vld_o}, 32'd0);
      chk("rst_ic_rdy",   {31'b0, ic_rdy_o},   32'd1);
      chk("rst_ic_req",   {31'b0, ic_req_o},   32'd0);
      chk("rst_core_gnt", {31'b0, core_gnt_o}, 32'd0);
      chk("rst_credit",   32'(dut.r_credit),   32'd0);
      chk("rst_stall",    stat_stall_o,        32'd0);
      chk("rst_reads",    stat_reads_o,        32'd0);
      rst_i = 1'b0;

      // Forwarded request fields pass straight through.
      core_addr_i  = 32'h1000_0040;
      core_wdata_i = 32'hCAFE_F00D;
      core_be_i    = 4'b1010;
      core_wen_i   = 1'b1;
      #1;
      chk("pass_addr",  ic_addr_o,  32'h1000_0040);
      chk("pass_wdata", ic_wdata_o, 32'hCAFE_F00D);
      chk("pass_be",    {28'b0, ic_be_o},  32'hA);
      chk("pass_wen",   {31'b0, ic_wen_o}, 32'd1);

      for (int i = 0; i < 13; i++) begin
         cyc(tbl[i].req, tbl[i].wen, tbl[i].gnt, tbl[i].vld, tbl[i].rdy, tbl[i].rdata);
         chk($sformatf("v%0d_ic_req", i),   {31'b0, ic_req_o},   {31'b0, tbl[i].e_ic_req});
         chk($sformatf("v%0d_core_gnt", i), {31'b0, core_gnt_o}, {31'b0, tbl[i].e_gnt});
         chk($sformatf("v%0d_core_vld", i), {31'b0, core_vld_o}, {31'b0, tbl[i].e_vld});
         chk($sformatf("v%0d_ic_rdy", i),   {31'b0, ic_rdy_o},   {31'b0, tbl[i].e_ic_rdy});
         chk($sformatf("v%0d_credit", i),   32'(dut.r_credit),   {30'b0, tbl[i].e_credit});
         if (tbl[i].e_vld)
            chk($sformatf("v%0d_rdata", i), core_rdata_o, tbl[i].e_rdata);
      end
      chk("tbl_stat_stall", stat_stall_o, ExpTblStall);
      chk("tbl_stat_reads", stat_reads_o, ExpTblReads);

      // Single read, response three cycles after the grant, visible one cycle after push.
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
      chk("a_gnt", {31'b0, core_gnt_o}, 32'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF);
      chk("a_no_bypass", {31'b0, core_vld_o}, 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      chk("a_vld",   {31'b0, core_vld_o}, 32'd1);
      chk("a_rdata", core_rdata_o, 32'hDEADBEEF);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      chk("a_vld_drop", {31'b0, core_vld_o}, 32'd0);
      chk("a_credit",   32'(dut.r_credit),   32'd0);

      // Backpressure: two responses held while the core stalls, then drained in order.
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h2);
      chk("b_vld_first", {31'b0, core_vld_o}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
         chk($sformatf("b_hold%0d_vld", i),   {31'b0, core_vld_o}, 32'd1);
         chk($sformatf("b_hold%0d_rdata", i), core_rdata_o, 32'h1);
         chk($sformatf("b_hold%0d_ic_rdy", i), {31'b0, ic_rdy_o}, 32'd0);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      chk("b_pop1", core_rdata_o, 32'h1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      chk("b_pop2_vld", {31'b0, core_vld_o}, 32'd1);
      chk("b_pop2",     core_rdata_o, 32'h2);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      chk("b_empty",  {31'b0, core_vld_o}, 32'd0);
      chk("b_credit", 32'(dut.r_credit),   32'd0);

      // Steady state at credit 1: grant+pop and push every cycle, pointers wrap repeatedly.
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd100);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'(101 + i));
         chk($sformatf("c%0d_rdata", i),  core_rdata_o, 32'(100 + i));
         chk($sformatf("c%0d_gnt", i),    {31'b0, core_gnt_o}, 32'd1);
         chk($sformatf("c%0d_credit", i), 32'(dut.r_credit),   32'd1);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      chk("c_last_rdata", core_rdata_o, 32'd110);
      chk("c_last_credit", 32'(dut.r_credit), 32'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      chk("c_empty",  {31'b0, core_vld_o}, 32'd0);
      chk("c_credit", 32'(dut.r_credit),   32'd0);

      // Reset with two buffered responses discards them and the credits.
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h55);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h66);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("d_full_vld",   {31'b0, core_vld_o}, 32'd1);
      chk("d_full_icrdy", {31'b0, ic_rdy_o},   32'd0);
      rst_i = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      rst_i = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("d_vld",    {31'b0, core_vld_o}, 32'd0);
      chk("d_ic_rdy", {31'b0, ic_rdy_o},   32'd1);
      chk("d_credit", 32'(dut.r_credit),   32'd0);
      chk("d_stall",  stat_stall_o,        32'd0);
      chk("d_reads",  stat_reads_o,        32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
